serial_adder: RTL and testbench

- Bit-serial, LSB-first adder built around one full-adder cell (two half adders plus OR) and a carry flip-flop.
- Accepts two WIDTH-bit operands on a start pulse and processes one bit per clock.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits downstream of the half-adder stage in the adder family: the first sequential consumer of the half-adder datapath, trading area for latency.

---
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, one bit per clock.
// Operands are latched on an accepted start; sum/carry are presented with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             sum_bit,
    output logic             sum_bit_valid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;

    // Full adder as two half adders joined by an OR on their carries.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_s, fa_c;
    assign ha1_s = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_c = a_sh_q[0] & b_sh_q[0];
    assign ha2_s = ha1_s ^ c_q;
    assign ha2_c = ha1_s & c_q;
    assign fa_s  = ha2_s;
    assign fa_c  = ha1_c | ha2_c;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d    = fa_c;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // Sum bits enter at the MSB so the LSB ends up in bit 0 after WIDTH shifts.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    carry_d = fa_c;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
        end
    end

    assign busy          = (state_q == RUN) || (state_q == DONE);
    assign done          = (state_q == DONE);
    assign sum           = sum_q;
    assign carry         = carry_q;
    assign sum_bit_valid = (state_q == RUN);
    assign sum_bit       = (state_q == RUN) & fa_s;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance, immediate-assert checks
// against hand-computed results.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, carry8, sbit8, sval8;
    logic [7:0] sum8;
    logic       busy1, done1, carry1, sbit1, sval1;
    logic [0:0] sum1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8),
        .sum_bit(sbit8), .sum_bit_valid(sval8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1),
        .sum_bit(sbit1), .sum_bit_valid(sval1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit addition: checks the serial stream bit by bit, then the done cycle.
    task automatic run8(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] exp_sum, input logic exp_c);
        a8 = ea; b8 = eb; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, sval8, 1);
            chk({tag, "_bit"}, sbit8, exp_sum[i]);
            chk({tag, "_nodone"}, done8, 0);
            tick();
        end
        chk({tag, "_done"}, done8, 1);
        chk({tag, "_busy_done"}, busy8, 1);
        chk({tag, "_sum"}, sum8, exp_sum);
        chk({tag, "_carry"}, carry8, exp_c);
        tick();
        chk({tag, "_idle"}, busy8, 0);
        chk({tag, "_done_low"}, done8, 0);
    endtask

    initial begin
        logic [7:0] ha [3];
        logic [7:0] hb [3];
        logic [7:0] hs [3];
        logic       hc [3];
        int         ndone;
        int         last_done;
        int         k;

        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h0; b8 = 8'h0; a1 = 1'b0; b1 = 1'b0;
        tick(); tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_carry", carry8, 0);
        chk("rst_sval", sval8, 0);
        chk("rst_sbit", sbit8, 0);
        chk("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        tick();

        // WIDTH=1: half-adder truth table
        for (int p = 0; p < 4; p++) begin
            a1 = 1'(p >> 1); b1 = 1'(p); start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_run_busy", busy1, 1);
            chk("w1_run_valid", sval1, 1);
            tick();
            chk("w1_done", done1, 1);
            chk("w1_sum", sum1, (p == 1 || p == 2) ? 1 : 0);
            chk("w1_carry", carry1, (p == 3) ? 1 : 0);
            tick();
            chk("w1_idle", busy1, 0);
        end

        run8("one_plus_one", 8'h01, 8'h01, 8'h02, 1'b0);

        // Full ripple: carry flop stays set from E1 through E8
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ripple_bit", sbit8, 0);
            tick();
            chk("ripple_cff", dut8.c_q, 1);
        end
        chk("ripple_done", done8, 1);
        chk("ripple_sum", sum8, 8'h00);
        chk("ripple_carry", carry8, 1);
        tick();

        // Start during RUN is ignored
        a8 = 8'hA5; b8 = 8'h5A; start8 = 1'b1;
        tick();
        a8 = 8'h11; b8 = 8'h22;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) start8 = 1'b0;
            if (done8) begin
                ndone++;
                chk("ign_done_time", i, 8);
                chk("ign_sum", sum8, 8'hFF);
                chk("ign_carry", carry8, 0);
            end
            tick();
        end
        chk("ign_done_count", ndone, 1);

        // Reset mid-RUN aborts with no done
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_carry", carry8, 0);
        chk("abort_sval", sval8, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        run8("after_abort", 8'h80, 8'h80, 8'h00, 1'b1);

        // start held high: three back-to-back additions
        ha[0] = 8'h12; hb[0] = 8'h34; hs[0] = 8'h46; hc[0] = 1'b0;
        ha[1] = 8'hF0; hb[1] = 8'h20; hs[1] = 8'h10; hc[1] = 1'b1;
        ha[2] = 8'h7F; hb[2] = 8'h7F; hs[2] = 8'hFE; hc[2] = 1'b0;
        k = 0; last_done = -1;
        a8 = ha[0]; b8 = hb[0]; start8 = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
            tick();
            if (done8) begin
                chk("held_sum", sum8, hs[k]);
                chk("held_carry", carry8, hc[k]);
                if (last_done >= 0) chk("held_spacing", cyc - last_done, 10);
                last_done = cyc;
                k++;
                if (k < 3) begin
                    a8 = ha[k]; b8 = hb[k];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        chk("held_count", k, 3);
        start8 = 1'b0;
        tick(); tick();
        chk("held_final_idle", busy8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
